// File: rtl/mem_master_port.sv
// Single-beat read/write initiator for one slave memory port.
// Optional read timeout with error response: define MEM_TIMEOUT_EN.
module mem_master_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  generate
    if (TIMEOUT_CYCLES < 3) begin : g_bad_timeout
      $error("mem_master_port: TIMEOUT_CYCLES must be >= 3");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  first_q, first_d;
  logic                  read_done;
  logic                  timeout_hit;

  // The first READ cycle may see rvalid left over from the previous read.
  assign read_done = mem_rvalid && !first_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // cnt_q counts READ cycles already spent; fires in cycle TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_READ) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == S_WRITE || (state_q == S_READ && read_done)) begin
      err_d = 1'b0;
    end else if (state_q == S_READ && timeout_hit) begin
      err_d = 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    first_d    = first_q;
    req_ready  = 1'b0;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Held low while rst is asserted so every output reads 0 in reset.
        req_ready = ~rst;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          first_d = 1'b1;
          state_d = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        mem_wen = 1'b1;
        state_d = S_RESP;
      end
      S_READ: begin
        mem_ren = 1'b1;
        first_d = 1'b0;
        if (read_done) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_master_port.sv
// Randomised self-checking bench for mem_master_port with a behavioural slave
// and a memory/timing reference model.
module tb_mem_master_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int LIM = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_wen, mem_ren, mem_rvalid;
  logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  mem_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Behavioural slave: two-cycle read latency, rvalid follows ren.
  logic [DW-1:0] smem [0:(1<<AW)-1];
  logic          st1, srv;
  logic [DW-1:0] srd;
  int            ren_cnt = 0;
  int            rv_mode = 0;   // 0 slave, 1 stuck low, 2 rise in READ cycle 16, 3 random
  logic          rv_rand = 1'b0;
  logic [DW-1:0] rd_rand = '0;

  always @(posedge clk) if (mem_wen) smem[mem_addr] <= mem_wdata;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st1 <= 1'b0; srv <= 1'b0; srd <= '0;
    end else begin
      st1 <= mem_ren; srv <= mem_ren & st1; srd <= smem[mem_addr];
    end
  end
  always @(posedge clk) ren_cnt <= mem_ren ? ren_cnt + 1 : 0;

  assign mem_rvalid = (rv_mode == 0) ? srv :
                      (rv_mode == 2) ? (mem_ren && ren_cnt >= TO - 1) :
                      (rv_mode == 3) ? rv_rand : 1'b0;
  assign mem_rdata  = (rv_mode == 2) ? 8'h5C : (rv_mode == 3) ? rd_rand : srd;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_last = '0;
  bit            rv_hist [0:LIM];
  logic [DW-1:0] rd_hist [0:LIM];

  // Observed results of one transaction
  int            o_wait, o_resp, o_wen, o_ren, o_rdy, o_both;
  logic [DW-1:0] o_rd, o_wd;
  logic [AW-1:0] o_wa;
  logic          o_err, o_ren_resp;

  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hold);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    o_wait = 0;
    while (!req_ready && o_wait < LIM) begin @(negedge clk); o_wait++; end
    @(posedge clk);
    o_resp = -1; o_wen = 0; o_ren = 0; o_rdy = 0; o_both = 0;
    o_rd = 'x; o_err = 1'bx; o_wa = 'x; o_wd = 'x; o_ren_resp = 1'b0;
    for (int k = 1; k <= LIM; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      if (mem_wen) begin o_wen++; o_wa = mem_addr; o_wd = mem_wdata; end
      if (mem_ren) o_ren++;
      if (mem_wen && mem_ren) o_both++;
      if (req_ready) o_rdy++;
      if (resp_valid) begin
        o_resp = k; o_rd = resp_rdata; o_err = resp_err; o_ren_resp = mem_ren;
        break;
      end
      if (rv_mode == 3) begin
        rv_rand = (k >= 6) ? 1'b1 : 1'(($urandom & 1));
        rd_rand = DW'($urandom_range(0, 255));
        rv_hist[k] = rv_rand; rd_hist[k] = rd_rand;
      end
    end
    $display("txn wr=%0d addr=%03h wdata=%02h resp_cycle=%0d rdata=%02h err=%0d",
             wr, a, d, o_resp, o_rd, o_err);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string nm);
    run_txn(1'b1, a, d, 1'b0);
    ref_mem[a] = d;
    checks++; if (o_resp !== 2) begin errors++; $display("FAIL %s wr_latency: got %0d want 2", nm, o_resp); end
    checks++; if (o_wen !== 1 || o_ren !== 0) begin errors++; $display("FAIL %s wr_enables: wen=%0d ren=%0d want 1/0", nm, o_wen, o_ren); end
    checks++; if (o_wa !== a || o_wd !== d) begin errors++; $display("FAIL %s wr_bus: got %03h/%02h want %03h/%02h", nm, o_wa, o_wd, a, d); end
    checks++; if (o_err !== 1'b0 || o_rd !== exp_last) begin errors++; $display("FAIL %s wr_resp: err=%0d rdata=%02h want 0/%02h", nm, o_err, o_rd, exp_last); end
    checks++; if (o_rdy !== 0 || o_wait !== 0 || o_both !== 0) begin errors++; $display("FAIL %s wr_handshake: rdy=%0d wait=%0d both=%0d want 0/0/0", nm, o_rdy, o_wait, o_both); end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit hold, input string nm);
    run_txn(1'b0, a, 8'h00, hold);
    exp_last = ref_mem[a];
    checks++; if (o_resp !== 4) begin errors++; $display("FAIL %s rd_latency: got %0d want 4", nm, o_resp); end
    checks++; if (o_ren !== 3 || o_wen !== 0 || o_ren_resp !== 1'b0) begin errors++; $display("FAIL %s rd_enables: ren=%0d wen=%0d ren_in_resp=%0d want 3/0/0", nm, o_ren, o_wen, o_ren_resp); end
    checks++; if (o_rd !== exp_last || o_err !== 1'b0) begin errors++; $display("FAIL %s rd_data: got %02h err=%0d want %02h err=0", nm, o_rd, o_err, exp_last); end
    checks++; if (o_rdy !== 0 || o_wait !== 0 || o_both !== 0) begin errors++; $display("FAIL %s rd_handshake: rdy=%0d wait=%0d both=%0d want 0/0/0", nm, o_rdy, o_wait, o_both); end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_wen, mem_ren} !== 5'b0 ||
        resp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL %s outputs_in_reset: ready=%0d rv=%0d err=%0d wen=%0d ren=%0d rdata=%02h addr=%03h wdata=%02h want all 0",
               nm, req_ready, resp_valid, resp_err, mem_wen, mem_ren, resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic release_reset(input string nm);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL %s ready_after_reset: ready=%0d rv=%0d want 1/0", nm, req_ready, resp_valid); end
    exp_last = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    release_reset("reset");
  endtask

  task automatic test_write_read();
    do_write(12'h123, 8'hA5, "wr123");
    do_read(12'h123, 1'b0, "rd123");
    do_write(12'h124, 8'h3C, "wr124_keep");
  endtask

  task automatic test_back_to_back();
    do_write(12'h010, 8'h11, "pre010");
    do_write(12'h011, 8'h22, "pre011");
    do_read(12'h010, 1'b1, "b2b_a");
    checks++; if (o_rd !== 8'h11) begin errors++; $display("FAIL b2b_first: got %02h want 11", o_rd); end
    do_read(12'h011, 1'b1, "b2b_b");
    checks++; if (o_rd !== 8'h22) begin errors++; $display("FAIL b2b_second: got %02h want 22", o_rd); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) do_write(AW'(12'h300 + i), DW'($urandom_range(0, 255)), "rnd_init");
    for (int i = 0; i < 30; i++) begin
      a = AW'(12'h300 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom_range(0, 255)), "rnd_wr");
      else do_read(a, 1'($urandom & 1), "rnd_rd");
    end
    @(negedge clk); req_valid = 1'b0;
  endtask

  // rvalid is random per READ cycle; the first qualifying one is READ cycle >= 2.
  task automatic test_random_rvalid();
    int k0;
    rv_mode = 3;
    for (int i = 0; i < 15; i++) begin
      run_txn(1'b0, AW'($urandom_range(0, 4095)), 8'h00, 1'b0);
      k0 = -1;
      for (int k = 2; k <= 6; k++) if (k0 < 0 && rv_hist[k]) k0 = k;
      checks++; if (o_resp !== k0 + 1 || o_ren !== k0) begin errors++; $display("FAIL rvrand_timing: resp=%0d ren=%0d want %0d/%0d", o_resp, o_ren, k0 + 1, k0); end
      checks++; if (o_rd !== rd_hist[k0] || o_err !== 1'b0) begin errors++; $display("FAIL rvrand_data: got %02h err=%0d want %02h err=0", o_rd, o_err, rd_hist[k0]); end
      exp_last = rd_hist[k0];
    end
    rv_mode = 0;
  endtask

  task automatic test_reset_mid_read();
    int seen;
    do_write(12'h200, 8'h6E, "pre200");
    @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h200;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1 check_all_zero("midread");
    seen = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midread_no_resp: saw %0d want 0", seen); end
    release_reset("midread");
    do_read(12'h200, 1'b0, "after_reset");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    rv_mode = 1;
    run_txn(1'b0, 12'h050, 8'h00, 1'b0);
    checks++; if (o_resp !== TO + 1 || o_ren !== TO || o_ren_resp !== 1'b0) begin errors++; $display("FAIL timeout_timing: resp=%0d ren=%0d ren_in_resp=%0d want %0d/%0d/0", o_resp, o_ren, o_ren_resp, TO + 1, TO); end
    checks++; if (o_err !== 1'b1 || o_rd !== 8'h00) begin errors++; $display("FAIL timeout_resp: err=%0d rdata=%02h want 1/00", o_err, o_rd); end
    rv_mode = 2;
    run_txn(1'b0, 12'h051, 8'h00, 1'b0);
    checks++; if (o_resp !== TO + 1 || o_ren !== TO) begin errors++; $display("FAIL late_rvalid_timing: resp=%0d ren=%0d want %0d/%0d", o_resp, o_ren, TO + 1, TO); end
    checks++; if (o_err !== 1'b0 || o_rd !== 8'h5C) begin errors++; $display("FAIL late_rvalid_resp: err=%0d rdata=%02h want 0/5C", o_err, o_rd); end
    rv_mode = 0;
    exp_last = 8'h5C;
  endtask
`else
  task automatic test_no_timeout();
    rv_mode = 1;
    run_txn(1'b0, 12'h050, 8'h00, 1'b0);
    checks++; if (o_resp !== -1 || o_ren !== LIM) begin errors++; $display("FAIL no_timeout_wait: resp=%0d ren=%0d want -1/%0d", o_resp, o_ren, LIM); end
    @(negedge clk); rst = 1'b1;
    #1 check_all_zero("no_timeout");
    rv_mode = 0;
    release_reset("no_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_random_rvalid();
    test_reset_mid_read();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    do_read(12'h123, 1'b0, "final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "bench time limit reached");
  end
endmodule

// File: doc/mem_master_port.md
# mem_master_port

Initiator for the slave memory port. Accepts single-beat read/write commands over a valid/ready request interface and drives the slave-side `wen`/`ren`/`addr`/`wdata` signals. It holds `ren` until the slave's `rvalid` and returns read data or a write acknowledgement on a one-cycle response strobe. It sits between a bus master or arbiter grant path and one `slave_memory_bram` instance.

## Interface
- `ADDR_WIDTH`, 12: address width; matches the slave.
- `DATA_WIDTH`, 8: data width.
- `TIMEOUT_CYCLES`, 16: maximum READ-state cycles before the read is aborted (only with `MEM_TIMEOUT_EN`); must be ≥ 3.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  command accepted when high together with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  command address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `resp_valid`  out  1  one-cycle completion strobe.
- `resp_rdata`  out  DATA_WIDTH  read data; valid with `resp_valid`.
- `resp_err`  out  1  read timed out; valid with `resp_valid`.
- `mem_wen`, `mem_ren`  out  1  slave write and read enables.
- `mem_addr`  out  ADDR_WIDTH  slave address.
- `mem_wdata`  out  DATA_WIDTH  slave write data.
- `mem_rdata`  in  DATA_WIDTH  slave read data.
- `mem_rvalid`  in  1  slave read-data valid.

## Operation
- States: IDLE, WRITE, READ, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the command is accepted: `req_addr` and `req_wdata` are registered onto `mem_addr`/`mem_wdata`.
  - Next state is WRITE if `req_write`=1, otherwise READ.
- **WRITE**
  - `mem_wen`=1 for exactly one cycle.
  - Next state is RESP with `resp_rdata` unchanged and `resp_err`=0.
- **READ**
  - `mem_ren`=1 for the whole state.
  - `mem_rvalid` is ignored in the first READ cycle, because the slave's `rvalid` may still be stale from a previous read.
  - From the second READ cycle on, `mem_rvalid`=1 causes `resp_rdata` to capture `mem_rdata` and the next state to be RESP.
- **RESP**
  - `resp_valid`=1 and `req_ready`=0 for one cycle.
  - All enables are low.
  - Next state is IDLE.
- `req_ready` is 0 outside IDLE. Requests presented then are not accepted and must be held by the requester.
- `mem_wen` and `mem_ren` are never high in the same cycle.
- `mem_addr` and `mem_wdata` hold their last values when idle.
- Reset, at any time including mid-read:
  - The state returns to IDLE immediately.
  - All outputs go to 0, including `req_ready`, `resp_rdata` and `resp_err`.
  - `req_ready` rises in the first cycle after `rst` deasserts.
  - An in-flight command is dropped with no response.

## Timing
- Accept edge = E0.
- Write:
  - `mem_wen` is high in cycle E0+1.
  - `resp_valid` is high in cycle E0+2.
  - The next accept is possible at the end of E0+3.
- Read against the slave memory:
  - `mem_ren` is high in cycles E0+1 through E0+3.
  - `mem_rvalid` is first seen high in E0+3.
  - `resp_valid` is high in E0+4.
- The RESP cycle (enables low) guarantees the slave clears `rvalid` before any following READ's second cycle.
- There is no back-to-back acceptance: throughput is at most one command per 3 cycles for writes and per 5 cycles for reads.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to READ and increments every READ cycle.
  - When the count reaches `TIMEOUT_CYCLES` without a qualifying `mem_rvalid`, the block goes to RESP with `resp_err`=1 and `resp_rdata`=0, and `mem_ren` drops.
  - A `mem_rvalid` seen in the same cycle as the timeout takes priority: the read completes normally with `resp_err`=0.
- `MEM_TIMEOUT_EN` undefined:
  - No counter is built.
  - READ waits indefinitely.
  - `resp_err` is tied to 0.

## Test plan
- Write `addr`=0x123, `wdata`=0xA5 → `mem_wen` high exactly one cycle with `mem_addr`=0x123 and `mem_wdata`=0xA5; `resp_valid` at E0+2 with `resp_err`=0.
- Read back 0x123 → `mem_ren` held 3 cycles; `resp_valid` at E0+4 with `resp_rdata`=0xA5.
- Back-to-back reads of 0x010 then 0x011, preloaded with 0x11 and 0x22, with `req_valid` held high → `req_ready` low during each transaction; responses 0x11 then 0x22, with no stale-`rvalid` capture.
- `rst` asserted during READ cycle 2 → all outputs 0 asynchronously; no `resp_valid`; `req_ready`=1 in the cycle after release; the next read returns correct data.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and `mem_rvalid` stuck at 0 → `resp_valid` with `resp_err`=1 and `resp_rdata`=0 after 16 READ cycles; `mem_ren` low in RESP.
- `MEM_TIMEOUT_EN` with `mem_rvalid` first rising in the 16th READ cycle and `mem_rdata`=0x5C → `resp_err`=0 and `resp_rdata`=0x5C.
